// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one subtract/compare unit between NREQ requesters.
// Each accepted compare runs IDLE -> EXEC -> RESP and returns a 1-bit result tagged with its id.
module cmp_sched #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*2-1:0]     req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_result,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q;
   logic [IDW-1:0]   rr_ptr_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       op_q;
   logic [IDW-1:0]   id_q;
   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   logic             rsp_result_q;

   logic             grant_vld;
   logic [IDW-1:0]   grant_id;
   logic [IDW-1:0]   grant_nxt;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [1:0]       op_sel;
   logic [WIDTH:0]   sum;
   logic             cout, zero, cmp_res;

   // Search starts at rr_ptr and wraps; the first valid requester wins.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      a_sel     = '0;
      b_sel     = '0;
      op_sel    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_id == IDW'(i)) begin
            req_ready[i] = (state_q == StIdle) && grant_vld;
            a_sel        = req_a[i*WIDTH +: WIDTH];
            b_sel        = req_b[i*WIDTH +: WIDTH];
            op_sel       = req_op[i*2 +: 2];
         end
      end
   end

   assign grant_nxt = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

   // a + ~b + 1: carry-out means A>=B, all-zero difference means A==B.
   assign sum  = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH + 1)'(1);
   assign cout = sum[WIDTH];
   assign zero = (sum[WIDTH-1:0] == '0);

   always_comb begin
      cmp_res = 1'b0;
      unique case (op_q)
         2'b00: cmp_res = cout & ~zero;
         2'b01: cmp_res = cout;
         2'b10: cmp_res = ~cout;
         2'b11: cmp_res = zero;
         default: cmp_res = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_vld) begin
                  a_q      <= a_sel;
                  b_q      <= b_sel;
                  op_q     <= op_sel;
                  id_q     <= grant_id;
                  rr_ptr_q <= grant_nxt;
                  state_q  <= StExec;
               end
            end
            StExec: begin
               rsp_result_q <= cmp_res;
               rsp_id_q     <= id_q;
               rsp_valid_q  <= 1'b1;
               state_q      <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign busy       = (state_q != StIdle);

endmodule
